// File: rtl/mc_main_ctrl.sv
// rtl/mc_main_ctrl.sv - multi-cycle RV32I main control FSM (optional OP-IMM via MC_CTRL_ITYPE_EN)
module mc_main_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       PCSource,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
`ifdef MC_CTRL_ITYPE_EN
        S_BRANCH = 4'd8,
        S_EXECI  = 4'd9
`else
        S_BRANCH = 4'd8
`endif
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef MC_CTRL_ITYPE_EN
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
`endif

    state_t cur, nxt;

    // zero only qualifies PCWriteCond inside the datapath's PC enable
    logic unused_zero;
    assign unused_zero = zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= S_FETCH;
        end else begin
            cur <= nxt;
        end
    end

    assign state = cur;

    always_comb begin
        nxt         = cur;
        ALUOp       = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        PCSource    = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        illegal     = 1'b0;

        case (cur)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    nxt     = S_DECODE;
                end
            end
            S_DECODE: begin
                // branch target = oldPC + imm, parked in ALUOut
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b10;
                case (opcode)
                    OP_LOAD, OP_STORE: nxt = S_MEMADR;
                    OP_RTYPE:          nxt = S_EXEC;
                    OP_BRANCH:         nxt = S_BRANCH;
`ifdef MC_CTRL_ITYPE_EN
                    OP_ITYPE:          nxt = S_EXECI;
`endif
                    default: begin
                        nxt     = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                if (opcode == OP_LOAD) begin
                    nxt = S_MEMRD;
                end else if (opcode == OP_STORE) begin
                    nxt = S_MEMWR;
                end else begin
                    nxt = S_FETCH;
                end
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    nxt = S_MEMWB;
                end
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                nxt      = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    nxt = S_FETCH;
                end
            end
            S_EXEC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b00;
                ALUOp   = 2'b10;
                nxt     = S_ALUWB;
            end
`ifdef MC_CTRL_ITYPE_EN
            S_EXECI: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b10;
                nxt     = S_ALUWB;
            end
`endif
            S_ALUWB: begin
                RegWrite = 1'b1;
                nxt      = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b00;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 1'b1;
                nxt         = S_FETCH;
            end
            default: nxt = S_FETCH;
        endcase

        // reset silences every strobe and select, even inside a memory wait
        if (rst) begin
            ALUOp       = 2'b00;
            ALUSrcA     = 2'b00;
            ALUSrcB     = 2'b00;
            PCSource    = 1'b0;
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            MemtoReg    = 1'b0;
            RegWrite    = 1'b0;
            illegal     = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_main_ctrl.sv
// tb/tb_mc_main_ctrl.sv - directed self-checking bench for mc_main_ctrl
module tb_mc_main_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic [1:0] ALUOp, ALUSrcA, ALUSrcB;
    logic       PCSource, PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
    logic       IRWrite, MemtoReg, RegWrite, illegal;
    logic [3:0] state;

    int tests_run = 0;
    int tests_failed = 0;

    mc_main_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    // {ALUOp, ALUSrcA, ALUSrcB, PCSource, PCWrite, PCWriteCond, IorD,
    //  MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, illegal}
    logic [15:0] ctl;
    assign ctl = {ALUOp, ALUSrcA, ALUSrcB, PCSource, PCWrite, PCWriteCond, IorD,
                  MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, illegal};

    localparam logic [15:0] W_OFF     = 16'h0000;
    localparam logic [15:0] W_FETCH   = 16'h0528;
    localparam logic [15:0] W_FWAIT   = 16'h0420;
    localparam logic [15:0] W_DECODE  = 16'h2800;
    localparam logic [15:0] W_ILLEGAL = 16'h2801;
    localparam logic [15:0] W_MEMADR  = 16'h1800;
    localparam logic [15:0] W_MEMRD   = 16'h0060;
    localparam logic [15:0] W_MEMWB   = 16'h0006;
    localparam logic [15:0] W_MEMWR   = 16'h0050;
    localparam logic [15:0] W_EXEC    = 16'h9000;
    localparam logic [15:0] W_ALUWB   = 16'h0002;
    localparam logic [15:0] W_BRANCH  = 16'h5280;
    localparam logic [15:0] W_EXECI   = 16'h9800;

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs on the falling edge, then check the settled outputs.
    task automatic step(input string tag, input logic r, input logic [6:0] op,
                        input logic rdy, input logic z,
                        input logic [3:0] exp_st, input logic [15:0] exp_w);
        @(negedge clk);
        rst       = r;
        opcode    = op;
        mem_ready = rdy;
        zero      = z;
        #1;
        check({tag, "_state"}, {28'd0, state}, {28'd0, exp_st});
        check({tag, "_ctl"}, {16'd0, ctl}, {16'd0, exp_w});
    endtask

    initial begin
        step("rst0", 1'b1, 7'd0, 1'b1, 1'b0, 4'd0, W_OFF);
        step("rst1", 1'b1, 7'd0, 1'b1, 1'b0, 4'd0, W_OFF);
        step("rst_rel_fetch", 1'b0, OP_R, 1'b1, 1'b0, 4'd0, W_FETCH);

        step("r_dec", 1'b0, OP_R, 1'b0, 1'b0, 4'd1, W_DECODE);
        step("r_exec", 1'b0, OP_R, 1'b0, 1'b0, 4'd6, W_EXEC);
        step("r_wb", 1'b0, OP_R, 1'b1, 1'b0, 4'd7, W_ALUWB);

        step("ld_fetch", 1'b0, OP_LD, 1'b1, 1'b0, 4'd0, W_FETCH);
        step("ld_dec", 1'b0, OP_LD, 1'b1, 1'b0, 4'd1, W_DECODE);
        step("ld_adr", 1'b0, OP_LD, 1'b1, 1'b0, 4'd2, W_MEMADR);
        for (int i = 0; i < 3; i++)
            step("ld_wait", 1'b0, OP_LD, 1'b0, 1'b0, 4'd3, W_MEMRD);
        step("ld_rd", 1'b0, OP_LD, 1'b1, 1'b0, 4'd3, W_MEMRD);
        step("ld_wb", 1'b0, OP_LD, 1'b1, 1'b0, 4'd4, W_MEMWB);

        step("st_fwait", 1'b0, OP_ST, 1'b0, 1'b0, 4'd0, W_FWAIT);
        step("st_fetch", 1'b0, OP_ST, 1'b1, 1'b0, 4'd0, W_FETCH);
        step("st_dec", 1'b0, OP_ST, 1'b1, 1'b0, 4'd1, W_DECODE);
        step("st_adr", 1'b0, OP_ST, 1'b1, 1'b0, 4'd2, W_MEMADR);
        step("st_wr", 1'b0, OP_ST, 1'b1, 1'b0, 4'd5, W_MEMWR);

        step("bz1_fetch", 1'b0, OP_BR, 1'b1, 1'b1, 4'd0, W_FETCH);
        step("bz1_dec", 1'b0, OP_BR, 1'b1, 1'b1, 4'd1, W_DECODE);
        step("bz1_br", 1'b0, OP_BR, 1'b1, 1'b1, 4'd8, W_BRANCH);
        step("bz0_fetch", 1'b0, OP_BR, 1'b1, 1'b0, 4'd0, W_FETCH);
        step("bz0_dec", 1'b0, OP_BR, 1'b1, 1'b0, 4'd1, W_DECODE);
        step("bz0_br", 1'b0, OP_BR, 1'b1, 1'b0, 4'd8, W_BRANCH);

        step("bad_fetch", 1'b0, OP_BAD, 1'b1, 1'b0, 4'd0, W_FETCH);
        step("bad_dec", 1'b0, OP_BAD, 1'b1, 1'b0, 4'd1, W_ILLEGAL);

        step("i_fetch", 1'b0, OP_I, 1'b1, 1'b0, 4'd0, W_FETCH);
`ifdef MC_CTRL_ITYPE_EN
        step("i_dec", 1'b0, OP_I, 1'b1, 1'b0, 4'd1, W_DECODE);
        step("i_execi", 1'b0, OP_I, 1'b1, 1'b0, 4'd9, W_EXECI);
        step("i_wb", 1'b0, OP_I, 1'b1, 1'b0, 4'd7, W_ALUWB);
`else
        step("i_dec_ill", 1'b0, OP_I, 1'b1, 1'b0, 4'd1, W_ILLEGAL);
`endif

        step("rw_fetch", 1'b0, OP_ST, 1'b1, 1'b0, 4'd0, W_FETCH);
        step("rw_dec", 1'b0, OP_ST, 1'b1, 1'b0, 4'd1, W_DECODE);
        step("rw_adr", 1'b0, OP_ST, 1'b1, 1'b0, 4'd2, W_MEMADR);
        step("rw_wait", 1'b0, OP_ST, 1'b0, 1'b0, 4'd5, W_MEMWR);
        step("rw_rst", 1'b1, OP_ST, 1'b0, 1'b0, 4'd5, W_OFF);
        step("rw_after", 1'b0, OP_ST, 1'b0, 1'b0, 4'd0, W_FWAIT);
        step("rw_refetch", 1'b0, OP_ST, 1'b1, 1'b0, 4'd0, W_FETCH);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
